stats_ctrl: RTL and testbench
=============================

Name: stats_ctrl

Overview:
Controller for the split-L1 cache statistics path. It owns the seven live event counters: instruction reads, hits and misses, and data reads, writes, hits and misses. It services clear (trace command 8) and print (trace command 9) requests. On print it snapshots the counters, computes totals and a fixed-point hit ratio with a sequential divider, then streams six report words out over a valid/ready port to the display/logging sink.

Parameters:
CW, 32, width of every counter and report data word
RW, 16, hit-ratio fraction bits (Q0.RW); also the divider iteration count

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ev_valid  in  1  one cache access resolved this cycle
ev_src  in  1  0 = instruction cache, 1 = data cache
ev_write  in  1  access was a write (only legal with ev_src=1)
ev_hit  in  1  access hit
clr  in  1  zero live counters (trace cmd 8)
print_req  in  1  start a report (trace cmd 9)
print_busy  out  1  report in progress; print_req ignored while high
rpt_valid  out  1  report word valid
rpt_ready  in  1  sink accepts word
rpt_id  out  3  0 HITS, 1 MISSES, 2 READS, 3 WRITES, 4 ACCESSES, 5 RATIO
rpt_data  out  CW  word value; RATIO is zero-extended Q0.RW
rpt_last  out  1  high with rpt_id=5

Behaviour:
- Reset (async, rst_n low):
  - Counters, snapshot and divider registers = 0; state = IDLE.
  - print_busy, rpt_valid, rpt_last = 0; rpt_id = 0; rpt_data = 0.
  - Reset mid-report aborts immediately; no partial word is held.
- Counting (any state, on clk rising):
  - ev_valid with ev_src=0 increments ins_reads plus ins_hit or ins_miss.
  - ev_src=1, ev_write=0 increments data_reads plus data_hit or data_miss.
  - ev_src=1, ev_write=1 increments data_writes plus data_hit or data_miss.
  - All counters saturate at 2^CW-1 and never wrap.
  - ev_src=0 with ev_write=1 is treated as a read.
- clr:
  - Zeroes all live counters next edge.
  - clr and ev_valid in the same cycle: clr wins and the event is dropped.
  - clr does not affect a report already in progress (it works from the snapshot).
- FSM IDLE -> SNAP -> DIV -> EMIT -> IDLE:
  - IDLE: print_req=1 captures the snapshot (pre-clr values if clr is coincident), sets print_busy, goes to SNAP.
  - SNAP (1 cycle), saturating CW-bit sums:
    - hits = ih + dh
    - misses = im + dm
    - reads = ir + dr
    - writes = dw
    - accesses = reads + writes
  - DIV (RW cycles): restoring fractional division, ratio = floor(hits * 2^RW / accesses).
    - rem = hits; each cycle rem <<= 1; if rem >= accesses then bit = 1 and rem -= accesses.
    - rem is CW+1 bits.
    - accesses = 0 forces ratio 0; hits >= accesses forces ratio 2^RW-1. The divider still runs its RW cycles in both cases.
  - EMIT: rpt_valid rises exactly RW+2 edges after the print_req sampling edge (18 for defaults).
    - Words are presented in id order 0..5.
    - id and data stay stable while rpt_valid & !rpt_ready.
    - Advance on valid & ready, with no gap cycle between words.
    - After id 5 transfers: rpt_valid, rpt_last and print_busy drop the next edge; return to IDLE.
- Events arriving during SNAP, DIV or EMIT update the live counters only and never the report in flight.
- print_req while print_busy is ignored and not queued.

Decomposition:
- stats_pkg holds:
  - report-id localparams RPT_HITS..RPT_RATIO
  - ev_src encodings SRC_INS / SRC_DATA
  - FSM state encoding
  - a saturating-add function
- One sub-module, stats_ratio_div: start/done handshake, CW-bit dividend and divisor, RW-bit quotient, fixed RW-cycle latency, including the special cases.
- Counters, snapshot and EMIT sequencing stay in stats_ctrl.

Test Plan:
- Mixed traffic, then print with rpt_ready held high:
  - Stimulus: 3 data reads (2 hit), 1 data write hit, 2 instruction fetches (1 hit).
  - Required words: HITS=4, MISSES=2, READS=5, WRITES=1, ACCESSES=6, RATIO=0xAAAA; rpt_last only on id 5.
  - Required timing: first rpt_valid 18 edges after print_req.
- Print with no traffic -> all words 0, RATIO=0; 4 data read hits then print -> RATIO=0xFFFF.
- Backpressure: hold rpt_ready low 5 cycles on each word -> rpt_id and rpt_data stable; no word lost or repeated; print_busy high throughout.
- Events during DIV/EMIT and a print_req mid-report:
  - The report still shows the snapshot; the second print_req is ignored.
  - A follow-up print shows the live totals including the mid-report events.
- clr and ev_valid in the same cycle -> counters 0, event dropped; CW=4 with 20 data read hits -> HITS=15 (saturated).
- rst_n asserted during EMIT id 2 -> rpt_valid and print_busy fall immediately; after release a fresh print reports zeros.

Source files
------------

// File: rtl/stats_pkg.sv
// rtl/stats_pkg.sv - shared encodings and helpers for the cache statistics controller
package stats_pkg;

  localparam logic [2:0] RPT_HITS     = 3'd0;
  localparam logic [2:0] RPT_MISSES   = 3'd1;
  localparam logic [2:0] RPT_READS    = 3'd2;
  localparam logic [2:0] RPT_WRITES   = 3'd3;
  localparam logic [2:0] RPT_ACCESSES = 3'd4;
  localparam logic [2:0] RPT_RATIO    = 3'd5;

  localparam logic SRC_INS  = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam int NUM_CNT = 7;
  localparam logic [2:0] CNT_IR = 3'd0;
  localparam logic [2:0] CNT_IH = 3'd1;
  localparam logic [2:0] CNT_IM = 3'd2;
  localparam logic [2:0] CNT_DR = 3'd3;
  localparam logic [2:0] CNT_DW = 3'd4;
  localparam logic [2:0] CNT_DH = 3'd5;
  localparam logic [2:0] CNT_DM = 3'd6;

  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SNAP = 2'd1,
    ST_DIV  = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  // Callers zero-extend to SAT_W and pass their real width w; result clamps at 2^w-1.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/stats_ratio_div.sv
// rtl/stats_ratio_div.sv - fixed-latency restoring divider producing a Q0.RW hit ratio
module stats_ratio_div #(
  parameter int CW = 32,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic          done,
  output logic [RW-1:0] quotient
);
  localparam int NW = $clog2(RW + 1);

  logic          run_q, run_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW:0]   rem_q, rem_d;
  logic [CW-1:0] dvs_q, dvs_d;
  logic [RW-1:0] quo_q, quo_d;
  logic          zero_q, zero_d, full_q, full_d;
  logic [CW:0]   rem_sh;

  assign rem_sh = rem_q << 1;

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    zero_d = zero_q;
    full_d = full_q;
    if (start) begin
      run_d  = 1'b1;
      cnt_d  = NW'(RW);
      rem_d  = {1'b0, dividend};
      dvs_d  = divisor;
      quo_d  = '0;
      zero_d = (divisor == '0);
      full_d = (dividend >= divisor);
    end else if (run_q) begin
      // Special cases still burn all RW iterations so latency never varies.
      if (cnt_q != '0) begin
        cnt_d = cnt_q - NW'(1);
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = rem_sh - {1'b0, dvs_q};
          quo_d = {quo_q[RW-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[RW-2:0], 1'b0};
        end
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      zero_q <= 1'b0;
      full_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      zero_q <= zero_d;
      full_q <= full_d;
    end
  end

  assign done     = run_q && (cnt_q == '0);
  assign quotient = zero_q ? '0 : (full_q ? '1 : quo_q);

endmodule

// File: rtl/stats_ctrl.sv
// rtl/stats_ctrl.sv - split-L1 event counters with clear, snapshot and streamed report
module stats_ctrl
  import stats_pkg::*;
#(
  parameter int CW = 32,
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ev_valid,
  input  logic          ev_src,
  input  logic          ev_write,
  input  logic          ev_hit,
  input  logic          clr,
  input  logic          print_req,
  output logic          print_busy,
  output logic          rpt_valid,
  input  logic          rpt_ready,
  output logic [2:0]    rpt_id,
  output logic [CW-1:0] rpt_data,
  output logic          rpt_last
);
  state_e state_q, state_d;
  logic [NUM_CNT-1:0][CW-1:0] cnt_q, cnt_d, snap_q, snap_d;
  logic [CW-1:0] hits_q, hits_d, miss_q, miss_d, reads_q, reads_d;
  logic [CW-1:0] writes_q, writes_d, acc_q, acc_d;
  logic [RW-1:0] ratio_q, ratio_d;
  logic [2:0]    id_q, id_d;
  logic [CW-1:0] s_hits, s_miss, s_reads, s_acc;
  logic          div_start, div_done;
  logic [RW-1:0] div_quo;

  function automatic logic [CW-1:0] sadd(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return CW'(sat_add(SAT_W'(a), SAT_W'(b), CW));
  endfunction

  assign s_hits  = sadd(snap_q[CNT_IH], snap_q[CNT_DH]);
  assign s_miss  = sadd(snap_q[CNT_IM], snap_q[CNT_DM]);
  assign s_reads = sadd(snap_q[CNT_IR], snap_q[CNT_DR]);
  assign s_acc   = sadd(s_reads, snap_q[CNT_DW]);

  assign div_start = (state_q == ST_SNAP);

  stats_ratio_div #(.CW(CW), .RW(RW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (s_hits),
    .divisor  (s_acc),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    hits_d   = hits_q;
    miss_d   = miss_q;
    reads_d  = reads_q;
    writes_d = writes_q;
    acc_d    = acc_q;
    ratio_d  = ratio_q;
    id_d     = id_q;

    // Live counting runs in every state; clr drops a coincident event.
    if (clr) begin
      cnt_d = '0;
    end else if (ev_valid) begin
      case (ev_src)
        SRC_INS: begin
          cnt_d[CNT_IR] = sadd(cnt_q[CNT_IR], CW'(1));
          if (ev_hit) cnt_d[CNT_IH] = sadd(cnt_q[CNT_IH], CW'(1));
          else        cnt_d[CNT_IM] = sadd(cnt_q[CNT_IM], CW'(1));
        end
        SRC_DATA: begin
          if (ev_write) cnt_d[CNT_DW] = sadd(cnt_q[CNT_DW], CW'(1));
          else          cnt_d[CNT_DR] = sadd(cnt_q[CNT_DR], CW'(1));
          if (ev_hit) cnt_d[CNT_DH] = sadd(cnt_q[CNT_DH], CW'(1));
          else        cnt_d[CNT_DM] = sadd(cnt_q[CNT_DM], CW'(1));
        end
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (print_req) begin
          snap_d  = cnt_q;
          state_d = ST_SNAP;
        end
      end
      ST_SNAP: begin
        hits_d   = s_hits;
        miss_d   = s_miss;
        reads_d  = s_reads;
        writes_d = snap_q[CNT_DW];
        acc_d    = s_acc;
        state_d  = ST_DIV;
      end
      ST_DIV: begin
        if (div_done) begin
          ratio_d = div_quo;
          id_d    = RPT_HITS;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rpt_ready) begin
          if (id_q == RPT_RATIO) begin
            id_d    = RPT_HITS;
            state_d = ST_IDLE;
          end else begin
            id_d = id_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      snap_q   <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      reads_q  <= '0;
      writes_q <= '0;
      acc_q    <= '0;
      ratio_q  <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      reads_q  <= reads_d;
      writes_q <= writes_d;
      acc_q    <= acc_d;
      ratio_q  <= ratio_d;
      id_q     <= id_d;
    end
  end

  assign print_busy = (state_q != ST_IDLE);
  assign rpt_valid  = (state_q == ST_EMIT);
  assign rpt_last   = rpt_valid && (id_q == RPT_RATIO);
  assign rpt_id     = id_q;

  always_comb begin
    rpt_data = '0;
    if (rpt_valid) begin
      case (id_q)
        RPT_HITS:     rpt_data = hits_q;
        RPT_MISSES:   rpt_data = miss_q;
        RPT_READS:    rpt_data = reads_q;
        RPT_WRITES:   rpt_data = writes_q;
        RPT_ACCESSES: rpt_data = acc_q;
        RPT_RATIO:    rpt_data = CW'(ratio_q);
        default:      rpt_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_stats_ctrl.sv
// tb/tb_stats_ctrl.sv - self-checking bench for stats_ctrl with a counting reference model
module tb_stats_ctrl;

  localparam int IR = 0, IH = 1, IM = 2, DR = 3, DW = 4, DH = 5, DM = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic ev_valid = 0, ev_src = 0, ev_write = 0, ev_hit = 0, clr = 0, print_req = 0, rpt_ready = 0;
  logic print_busy, rpt_valid, rpt_last;
  logic [2:0] rpt_id;
  logic [31:0] rpt_data;

  logic s_ev_valid = 0, s_ev_src = 0, s_ev_write = 0, s_ev_hit = 0, s_clr = 0, s_print_req = 0, s_rpt_ready = 0;
  logic s_print_busy, s_rpt_valid, s_rpt_last;
  logic [2:0] s_rpt_id;
  logic [3:0] s_rpt_data;

  stats_ctrl #(.CW(32), .RW(16)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_src(ev_src), .ev_write(ev_write),
    .ev_hit(ev_hit), .clr(clr), .print_req(print_req), .print_busy(print_busy),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_id(rpt_id), .rpt_data(rpt_data),
    .rpt_last(rpt_last)
  );

  stats_ctrl #(.CW(4), .RW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ev_valid(s_ev_valid), .ev_src(s_ev_src), .ev_write(s_ev_write),
    .ev_hit(s_ev_hit), .clr(s_clr), .print_req(s_print_req), .print_busy(s_print_busy),
    .rpt_valid(s_rpt_valid), .rpt_ready(s_rpt_ready), .rpt_id(s_rpt_id), .rpt_data(s_rpt_data),
    .rpt_last(s_rpt_last)
  );

  int cur = 0;
  logic o_busy, o_valid, o_last;
  logic [2:0] o_id;
  logic [63:0] o_data;

  always_comb begin
    if (cur == 1) begin
      o_busy = s_print_busy; o_valid = s_rpt_valid; o_last = s_rpt_last;
      o_id = s_rpt_id; o_data = 64'(s_rpt_data);
    end else begin
      o_busy = print_busy; o_valid = rpt_valid; o_last = rpt_last;
      o_id = rpt_id; o_data = 64'(rpt_data);
    end
  end

  int errors = 0;
  int checks = 0;
  longint cnt [2][7];
  int cwv [2] = '{32, 4};
  int rwv [2] = '{16, 4};
  longint exp_w [6];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint min2(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic bump(input int s, input int k);
    longint mx;
    mx = (longint'(1) << cwv[s]) - 1;
    if (cnt[s][k] < mx) cnt[s][k]++;
  endtask

  task automatic apply(input int s, input bit v, input bit src, input bit wr, input bit hit, input bit c);
    if (c) begin
      for (int k = 0; k < 7; k++) cnt[s][k] = 0;
    end else if (v) begin
      if (!src) begin
        bump(s, IR);
        bump(s, hit ? IH : IM);
      end else begin
        bump(s, wr ? DW : DR);
        bump(s, hit ? DH : DM);
      end
    end
  endtask

  task automatic set_in(input int s, input bit v, input bit src, input bit wr, input bit hit,
                        input bit c, input bit pr);
    if (s == 0) begin
      ev_valid = v; ev_src = src; ev_write = wr; ev_hit = hit; clr = c; print_req = pr;
    end else begin
      s_ev_valid = v; s_ev_src = src; s_ev_write = wr; s_ev_hit = hit; s_clr = c; s_print_req = pr;
    end
    apply(s, v, src, wr, hit, c);
  endtask

  task automatic set_ready(input int s, input bit r);
    if (s == 0) rpt_ready = r;
    else s_rpt_ready = r;
  endtask

  task automatic idle_in(input int s);
    set_in(s, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ev(input int s, input bit src, input bit wr, input bit hit);
    set_in(s, 1, src, wr, hit, 0, 0);
    step();
    idle_in(s);
  endtask

  task automatic rand_in(input int s, input bit allow_pr);
    bit v, src, wr, hit, pr;
    v = 1'($urandom_range(0, 1));
    src = 1'($urandom_range(0, 1));
    wr = 1'($urandom_range(0, 1));
    hit = 1'($urandom_range(0, 1));
    pr = allow_pr && ($urandom_range(0, 3) == 0);
    set_in(s, v, src, wr, hit, 0, pr);
  endtask

  task automatic model_exp(input int s);
    longint mx, h, r, a;
    mx = (longint'(1) << cwv[s]) - 1;
    h = min2(cnt[s][IH] + cnt[s][DH], mx);
    r = min2(cnt[s][IR] + cnt[s][DR], mx);
    a = min2(r + cnt[s][DW], mx);
    exp_w[0] = h;
    exp_w[1] = min2(cnt[s][IM] + cnt[s][DM], mx);
    exp_w[2] = r;
    exp_w[3] = cnt[s][DW];
    exp_w[4] = a;
    if (a == 0) exp_w[5] = 0;
    else if (h >= a) exp_w[5] = (longint'(1) << rwv[s]) - 1;
    else exp_w[5] = (h << rwv[s]) / a;
  endtask

  task automatic wait_valid(input int s, input bit inject, output int n);
    n = 0;
    while (!o_valid && n < 200) begin
      if (inject) rand_in(s, 1);
      step();
      n++;
    end
    idle_in(s);
  endtask

  task automatic print_report(input int s, input bit use_model, input int stall, input bit inject);
    int n;
    cur = s;
    if (use_model) model_exp(s);
    set_in(s, 0, 0, 0, 0, 0, 1);
    set_ready(s, stall == 0);
    step();
    idle_in(s);
    wait_valid(s, inject, n);
    check("latency", 64'(n), 64'(rwv[s] + 2));
    for (int i = 0; i < 6; i++) begin
      check($sformatf("w%0d_busy", i), 64'(o_busy), 64'd1);
      check($sformatf("w%0d_valid", i), 64'(o_valid), 64'd1);
      check($sformatf("w%0d_id", i), 64'(o_id), 64'(i));
      check($sformatf("w%0d_data", i), o_data, exp_w[i]);
      check($sformatf("w%0d_last", i), 64'(o_last), 64'(i == 5));
      for (int st = 0; st < stall; st++) begin
        set_ready(s, 0);
        if (inject) rand_in(s, 1);
        step();
        check($sformatf("w%0d_hold_id", i), 64'(o_id), 64'(i));
        check($sformatf("w%0d_hold_data", i), o_data, exp_w[i]);
        check($sformatf("w%0d_hold_busy", i), 64'(o_valid & o_busy), 64'd1);
      end
      set_ready(s, 1);
      if (inject) rand_in(s, 1);
      step();
    end
    set_ready(s, 0);
    idle_in(s);
    check("end_valid", 64'(o_valid), 64'd0);
    check("end_busy", 64'(o_busy), 64'd0);
    check("end_last", 64'(o_last), 64'd0);
  endtask

  initial begin
    int n;
    for (int s = 0; s < 2; s++) for (int k = 0; k < 7; k++) cnt[s][k] = 0;
    repeat (2) step();
    check("rst_busy", 64'(print_busy), 64'd0);
    check("rst_valid", 64'(rpt_valid), 64'd0);
    check("rst_last", 64'(rpt_last), 64'd0);
    check("rst_id", 64'(rpt_id), 64'd0);
    check("rst_data", 64'(rpt_data), 64'd0);
    check("rst_busy4", 64'(s_print_busy), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed mixed traffic
    ev(0, 1, 0, 1); ev(0, 1, 0, 1); ev(0, 1, 0, 0);
    ev(0, 1, 1, 1); ev(0, 0, 0, 1); ev(0, 0, 0, 0);
    exp_w = '{4, 2, 5, 1, 6, 'hAAAA};
    print_report(0, 0, 0, 0);

    // Cleared counters report zeros
    set_in(0, 0, 0, 0, 0, 1, 0); step(); idle_in(0);
    exp_w = '{0, 0, 0, 0, 0, 0};
    print_report(0, 0, 0, 0);

    // All hits saturate the ratio
    for (int i = 0; i < 4; i++) ev(0, 1, 0, 1);
    exp_w = '{4, 0, 4, 0, 4, 'hFFFF};
    print_report(0, 0, 0, 0);

    // Random traffic with backpressure
    set_in(0, 0, 0, 0, 0, 1, 0); step(); idle_in(0);
    for (int i = 0; i < 30; i++) begin rand_in(0, 0); step(); end
    idle_in(0);
    print_report(0, 1, 5, 0);

    // Events and print requests during the report, then a follow-up print
    for (int i = 0; i < 20; i++) begin rand_in(0, 0); step(); end
    idle_in(0);
    print_report(0, 1, 1, 1);
    print_report(0, 1, 0, 0);

    // clr beats a coincident event
    ev(0, 0, 0, 1); ev(0, 1, 1, 0);
    set_in(0, 1, 1, 0, 1, 1, 0); step(); idle_in(0);
    exp_w = '{0, 0, 0, 0, 0, 0};
    print_report(0, 0, 0, 0);

    // Narrow instance saturates
    for (int i = 0; i < 20; i++) ev(1, 1, 0, 1);
    exp_w = '{15, 0, 15, 0, 15, 15};
    print_report(1, 0, 0, 0);

    // Reset while word 2 is presented
    cur = 0;
    for (int i = 0; i < 5; i++) begin rand_in(0, 0); step(); end
    set_in(0, 0, 0, 0, 0, 0, 1); set_ready(0, 1); step(); idle_in(0);
    wait_valid(0, 0, n);
    check("rst_run_latency", 64'(n), 64'd18);
    step(); step();
    check("rst_pre_id", 64'(rpt_id), 64'd2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 64'(rpt_valid), 64'd0);
    check("rst_mid_busy", 64'(print_busy), 64'd0);
    check("rst_mid_id", 64'(rpt_id), 64'd0);
    check("rst_mid_data", 64'(rpt_data), 64'd0);
    set_ready(0, 0);
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) for (int k = 0; k < 7; k++) cnt[s][k] = 0;
    step();
    exp_w = '{0, 0, 0, 0, 0, 0};
    print_report(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
